// File: rtl/wdata_gen_pkg.sv
// wdata_gen_pkg: shared pattern types, constants and LFSR step for the write-data generator
package wdata_gen_pkg;
    typedef enum logic [1:0] {PAT_INCR, PAT_LFSR, PAT_CONST, PAT_WALK} pat_t;
    localparam logic [31:0] LFSR_POLY  = 32'h8020_0003;
    localparam logic [31:0] CONST_WORD = 32'hF0F0_F0F0;
    localparam int          LANE_W     = 32;
    // LFSR_POLY is in implicit-+1 (Koopman) form; shifted back it gives the x^22+x^2+x+1 tap mask
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], 1'b0} ^ (s[31] ? {LFSR_POLY[30:0], 1'b1} : 32'h0);
    endfunction
endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through synchronous FIFO
//   aclk/aresetn : clock, async active-low reset (clears pointers)
//   wr_en/din    : push, ignored while full
//   rd_en        : pop head, ignored while empty
//   dout         : head word (zero while empty)
//   empty/full/count : status from extended-pointer compare
module sync_fifo_fwft #(
    parameter int WIDTH = 257,
    parameter int DEPTH = 16
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           din,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_wr, do_rd;
    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
    always_ff @(posedge aclk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/wdata_stream_gen.sv
// wdata_stream_gen: write-data pattern generator feeding a FWFT FIFO for the AXI W channel
//   aclk/aresetn : clock, async active-low reset
//   enable       : generator runs while 1 and FIFO not full
//   mode         : pattern select, latched only while enable=0
//   rd_en        : consumer pop (accepted W beat)
//   dout/dout_last : head word and its end-of-burst flag
//   fifo_empty/fifo_full/fifo_count : FIFO status
//   beat_count   : words generated since reset
module wdata_stream_gen
    import wdata_gen_pkg::*;
#(
    parameter int          DATA_WIDTH = 256,
    parameter int          FIFO_DEPTH = 16,
    parameter int          BURST_LEN  = 16,
    parameter logic [31:0] SEED       = 32'h0000_0001
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          enable,
    input  logic [1:0]                    mode,
    input  logic                          rd_en,
    output logic [DATA_WIDTH-1:0]         dout,
    output logic                          dout_last,
    output logic                          fifo_empty,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [31:0]                   beat_count
);
    localparam int L  = DATA_WIDTH / LANE_W;
    localparam int BW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
    pat_t                  mode_q;
    logic [31:0]           seq, lfsr;
    logic [BW-1:0]         burst_cnt;
    logic [DATA_WIDTH-1:0] lanes, walk, pat;
    logic [DATA_WIDTH:0]   fifo_dout;
    logic                  gen_fire, last;
    assign gen_fire  = enable & ~fifo_full;
    assign last      = burst_cnt == BW'(BURST_LEN - 1);
    assign walk      = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << (seq % 32'(DATA_WIDTH));
    assign pat       = mode_q == PAT_WALK ? walk : lanes;
    assign dout      = fifo_dout[DATA_WIDTH-1:0];
    assign dout_last = fifo_dout[DATA_WIDTH];
    always_comb begin
        lanes = '0;
        for (int i = 0; i < L; i++)
            lanes[i*LANE_W +: LANE_W] = mode_q == PAT_INCR ? seq * 32'(L) + 32'(i) :
                                        mode_q == PAT_LFSR ? lfsr ^ 32'(i) : CONST_WORD;
    end
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mode_q     <= PAT_INCR;
            seq        <= '0;
            lfsr       <= SEED;
            burst_cnt  <= '0;
            beat_count <= '0;
        end else begin
            if (!enable) mode_q <= pat_t'(mode);
            if (gen_fire) begin
                seq        <= seq + 32'd1;
                lfsr       <= lfsr_next(lfsr);
                burst_cnt  <= last ? '0 : burst_cnt + BW'(1);
                beat_count <= beat_count + 32'd1;
            end
        end
    end
    sync_fifo_fwft #(.WIDTH(DATA_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .wr_en   (gen_fire),
        .din     ({last, pat}),
        .rd_en   (rd_en),
        .dout    (fifo_dout),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );
endmodule

// File: tb/tb_wdata_stream_gen.sv
// tb_wdata_stream_gen: directed self-checking bench for wdata_stream_gen
module tb_wdata_stream_gen;
    logic         aclk = 1'b0;
    logic         aresetn, enable, rd_en;
    logic [1:0]   mode;
    logic [255:0] dout;
    logic         dout_last, fifo_empty, fifo_full;
    logic [4:0]   fifo_count;
    logic [31:0]  beat_count;
    int           n_checks = 0;
    int           n_fail = 0;
    always #5 aclk = ~aclk;
    wdata_stream_gen dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .enable     (enable),
        .mode       (mode),
        .rd_en      (rd_en),
        .dout       (dout),
        .dout_last  (dout_last),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .fifo_count (fifo_count),
        .beat_count (beat_count)
    );
    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic do_reset(input logic en, input logic [1:0] m);
        @(negedge aclk);
        aresetn = 1'b0;
        enable  = en;
        mode    = m;
        rd_en   = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
    endtask
    function automatic logic [255:0] incr_word(input int n);
        logic [255:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = 32'(n * 8 + i);
        return w;
    endfunction
    function automatic logic [255:0] lfsr_word(input logic [31:0] l);
        logic [255:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = l ^ 32'(i);
        return w;
    endfunction
    initial begin
        logic [31:0]  l;
        logic [255:0] one;
        logic [255:0] cw;
        one = 256'd1;
        for (int i = 0; i < 8; i++) cw[i*32 +: 32] = 32'hF0F0_F0F0;
        // reset held with enable high
        aresetn = 1'b0; enable = 1'b1; rd_en = 1'b0; mode = 2'd0;
        repeat (3) @(negedge aclk);
        check("rst_empty", fifo_empty, 1);
        check("rst_full", fifo_full, 0);
        check("rst_count", fifo_count, 0);
        check("rst_beat", beat_count, 0);
        check("rst_dout", dout, 0);
        check("rst_last", dout_last, 0);
        aresetn = 1'b1;
        @(negedge aclk);
        check("t1_first", dout, incr_word(0));
        check("t1_count", fifo_count, 1);
        check("t1_empty", fifo_empty, 0);
        // fill and stall
        repeat (15) @(negedge aclk);
        check("t2_full", fifo_full, 1);
        check("t2_count", fifo_count, 16);
        check("t2_beat", beat_count, 16);
        repeat (3) @(negedge aclk);
        check("t2_stall_beat", beat_count, 16);
        rd_en = 1'b1;
        @(negedge aclk);
        rd_en = 1'b0;
        check("t2_pop_count", fifo_count, 15);
        check("t2_pop_beat", beat_count, 16);
        check("t2_pop_head", dout, incr_word(1));
        @(negedge aclk);
        check("t2_refill_count", fifo_count, 16);
        check("t2_refill_beat", beat_count, 17);
        @(negedge aclk);
        check("t2_hold_beat", beat_count, 17);
        // burst flag with continuous draining
        do_reset(1'b1, 2'd0);
        rd_en = 1'b1;
        for (int n = 0; n < 48; n++) begin
            @(negedge aclk);
            check("t3_lane0", dout[31:0], 32'(8 * n));
            check("t3_last", dout_last, (n % 16) == 15);
            if (n == 5) begin
                check("t3_count1", fifo_count, 1);
                check("t3_not_empty", fifo_empty, 0);
            end
        end
        check("t3_beat", beat_count, 48);
        // LFSR pattern against reference model from the polynomial taps
        do_reset(1'b0, 2'd1);
        @(negedge aclk);
        check("t4_idle_beat", beat_count, 0);
        enable = 1'b1;
        rd_en  = 1'b1;
        l = 32'h1;
        for (int n = 0; n < 1000; n++) begin
            @(negedge aclk);
            if (n < 3) check("t4_head", dout[31:0], one[31:0] << n);
            check("t4_word", dout, lfsr_word(l));
            l = {l[30:0], 1'b0} ^ (l[31] ? 32'h0040_0007 : 32'h0);
        end
        // pop on empty, CONST pattern, mode change ignored while enabled
        do_reset(1'b0, 2'd2);
        rd_en = 1'b1;
        @(negedge aclk);
        rd_en = 1'b0;
        check("t5_empty", fifo_empty, 1);
        check("t5_count", fifo_count, 0);
        check("t5_beat", beat_count, 0);
        check("t5_dout", dout, 0);
        enable = 1'b1;
        @(negedge aclk);
        mode = 2'd0;
        @(negedge aclk);
        enable = 1'b0;
        check("t5_const_count", fifo_count, 2);
        check("t5_const0", dout, cw);
        rd_en = 1'b1;
        @(negedge aclk);
        rd_en = 1'b0;
        check("t5_const1", dout, cw);
        check("t5_const_pop", fifo_count, 1);
        // WALK wraps after DATA_WIDTH words
        do_reset(1'b0, 2'd3);
        @(negedge aclk);
        enable = 1'b1;
        rd_en  = 1'b1;
        for (int n = 0; n < 258; n++) begin
            @(negedge aclk);
            if (n == 0 || n == 1 || n == 255 || n == 256)
                check("t5_walk", dout, one << (n % 256));
        end
        // asynchronous reset mid-operation
        do_reset(1'b1, 2'd1);
        repeat (9) @(negedge aclk);
        enable = 1'b0;
        check("t6_count9", fifo_count, 9);
        #2 aresetn = 1'b0;
        #1;
        check("t6_async_empty", fifo_empty, 1);
        check("t6_async_count", fifo_count, 0);
        check("t6_async_dout", dout, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        enable  = 1'b1;
        mode    = 2'd0;
        @(negedge aclk);
        enable = 1'b0;
        check("t6_restart", dout, incr_word(0));
        check("t6_beat", beat_count, 1);
        mode = 2'd1;
        @(negedge aclk);
        enable = 1'b1;
        rd_en  = 1'b1;
        @(negedge aclk);
        enable = 1'b0;
        rd_en  = 1'b0;
        check("t6_lfsr", dout[31:0], 32'h2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
